// File: rtl/mips_pkg.sv
// Shared constants for the multi-core MIPS pipeline.
// Data-path blocks take their default word width from here.
package mips_pkg;

    localparam int WORD_W = 32;

endpackage : mips_pkg

// File: rtl/nreg_en.sv
// N-bit register with load enable and synchronous active-low clear.
// Holds its value whenever en is low.
module nreg_en
    import mips_pkg::*;
#(
    parameter int N = WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : nreg_en

// File: rtl/pipe_skid_stage.sv
// Registered valid/ready stage with a one-entry skid buffer and synchronous flush.
// The state is the pair of valid bits (main_v, skid_v); data lives in two nreg_en instances.
//
//   state  (main_v,skid_v) | meaning
//   EMPTY  (0,0)           | nothing held, in_ready=1
//   ONE    (1,0)           | word in main, skid free, in_ready=1
//   FULL   (1,1)           | main and skid both held, in_ready=0
//   --     (0,1)           | unreachable; skid only fills behind a valid main
module pipe_skid_stage
    import mips_pkg::*;
#(
    parameter int N = WORD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic         main_v;
    logic         skid_v;
    logic         main_v_nx;
    logic         skid_v_nx;
    logic         main_ld;
    logic         main_from_skid;
    logic         skid_ld;
    logic [N-1:0] main_d;
    logic [N-1:0] skid_d;
    logic [N-1:0] main_in;
    logic         acc;
    logic         pop;

    // in_ready depends only on a register, so upstream never sees a path through this stage.
    assign acc = in_valid && !skid_v;
    assign pop = main_v && out_ready;

    always_comb begin
        main_v_nx      = main_v;
        skid_v_nx      = skid_v;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;

        if (!main_v) begin
            if (acc) begin
                main_ld   = 1'b1;
                main_v_nx = 1'b1;
            end
        end else if (pop) begin
            if (skid_v) begin
                main_ld        = 1'b1;
                main_from_skid = 1'b1;
                skid_v_nx      = 1'b0;
            end else if (acc) begin
                main_ld = 1'b1;
            end else begin
                main_v_nx = 1'b0;
            end
        end else if (acc) begin
            skid_ld   = 1'b1;
            skid_v_nx = 1'b1;
        end

        // Flush wins over every case; a word offered alongside it is simply dropped.
        if (flush) begin
            main_v_nx = 1'b0;
            skid_v_nx = 1'b0;
            main_ld   = 1'b0;
            skid_ld   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else begin
            main_v <= main_v_nx;
            skid_v <= skid_v_nx;
        end
    end

    assign main_in = main_from_skid ? skid_d : in_data;

    nreg_en #(.N(N)) u_main_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_ld),
        .d     (main_in),
        .q     (main_d)
    );

    nreg_en #(.N(N)) u_skid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_ld),
        .d     (in_data),
        .q     (skid_d)
    );

    assign out_valid = main_v;
    assign out_data  = main_d;
    assign in_ready  = !skid_v;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vector table, then random traffic against a queue model.
module tb_pipe_skid_stage;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   occupancy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    typedef struct {
        logic         rst_n;
        logic         flush;
        logic         in_valid;
        logic [N-1:0] in_data;
        logic         out_ready;
        logic         exp_ov;
        logic         chk_d;
        logic [N-1:0] exp_od;
        logic         exp_ir;
        logic [1:0]   exp_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic iv, input logic [N-1:0] d,
                       input logic ordy, input logic ov, input logic cd, input logic [N-1:0] od,
                       input logic ir, input logic [1:0] occ);
        vec_t v;
        v = '{r, f, iv, d, ordy, ov, cd, od, ir, occ};
        vecs.push_back(v);
    endtask

    // Model: the held words as a FIFO of at most two entries.
    logic [N-1:0] model_q[$];

    initial begin
        // Each row: inputs for one cycle, expected outputs just after that edge.
        add(0,0,1,32'h12345678,0, 0,1,32'h0,       1,0);
        add(0,0,1,32'h12345678,0, 0,1,32'h0,       1,0);
        add(1,0,1,32'h12345678,0, 1,1,32'h12345678,1,1);
        add(1,0,1,32'hAAAAAAAA,1, 1,1,32'hAAAAAAAA,1,1);
        add(1,0,1,32'hBBBBBBBB,1, 1,1,32'hBBBBBBBB,1,1);
        add(1,0,1,32'hCCCCCCCC,1, 1,1,32'hCCCCCCCC,1,1);
        add(1,0,0,32'h0,       1, 0,0,32'h0,       1,0);
        add(1,0,1,32'hAAAAAAAA,0, 1,1,32'hAAAAAAAA,1,1);
        add(1,0,1,32'hBBBBBBBB,0, 1,1,32'hAAAAAAAA,0,2);
        add(1,0,1,32'hCCCCCCCC,0, 1,1,32'hAAAAAAAA,0,2);
        add(1,0,1,32'hCCCCCCCC,1, 1,1,32'hBBBBBBBB,1,1);
        add(1,0,1,32'hCCCCCCCC,1, 1,1,32'hCCCCCCCC,1,1);
        add(1,0,0,32'h0,       1, 0,0,32'h0,       1,0);
        add(1,0,1,32'hAAAAAAAA,0, 1,1,32'hAAAAAAAA,1,1);
        add(1,0,1,32'hBBBBBBBB,0, 1,1,32'hAAAAAAAA,0,2);
        add(1,1,1,32'hDEADBEEF,0, 0,0,32'h0,       1,0);
        add(1,0,0,32'h0,       0, 0,0,32'h0,       1,0);
        add(1,0,1,32'h11111111,0, 1,1,32'h11111111,1,1);
        add(1,0,1,32'h22222222,1, 1,1,32'h22222222,1,1);
        add(1,0,0,32'h0,       1, 0,0,32'h0,       1,0);
        add(1,0,1,32'h33333333,0, 1,1,32'h33333333,1,1);
        add(1,1,1,32'h44444444,1, 0,0,32'h0,       1,0);
        add(1,0,1,32'h55555555,0, 1,1,32'h55555555,1,1);
        add(1,0,1,32'h66666666,0, 1,1,32'h55555555,0,2);
        add(0,1,1,32'h77777777,1, 0,1,32'h0,       1,0);
        add(1,0,0,32'h0,       0, 0,0,32'h0,       1,0);

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n     = vecs[i].rst_n;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].in_valid;
            in_data   = vecs[i].in_data;
            out_ready = vecs[i].out_ready;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), N'(out_valid), N'(vecs[i].exp_ov));
            check($sformatf("vec%0d in_ready", i),  N'(in_ready),  N'(vecs[i].exp_ir));
            check($sformatf("vec%0d occupancy", i), N'(occupancy), N'(vecs[i].exp_occ));
            if (vecs[i].chk_d)
                check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_od);
        end

        // Random traffic; stage is empty here, so the model starts empty.
        model_q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic acc_m;
            logic pop_m;
            rst_n     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);

            acc_m = in_valid && (model_q.size() < 2);
            pop_m = (model_q.size() > 0) && out_ready;
            if (!rst_n || flush) begin
                model_q.delete();
            end else begin
                if (pop_m) void'(model_q.pop_front());
                if (acc_m) model_q.push_back(in_data);
            end

            @(posedge clk);
            #1;
            check("rnd out_valid", N'(out_valid), N'(model_q.size() > 0));
            check("rnd in_ready",  N'(in_ready),  N'(model_q.size() < 2));
            check("rnd occupancy", N'(occupancy), N'(model_q.size()));
            if (model_q.size() > 0)
                check("rnd out_data", out_data, model_q[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_pipe_skid_stage
